muller_pipe_sync: RTL and testbench

//  Clocked, parametrised successor to the async C-element: STAGES-deep 4-phase

---
 rtl/muller_pipe_sync_pkg.sv | 35 +++
 rtl/muller_pipe_sync_c.sv | 23 ++
 rtl/muller_pipe_sync.sv | 104 ++++++++++
 tb/tb_muller_pipe_sync.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muller_pipe_sync_pkg.sv
// Shared definitions for the clocked micropipeline: C-element next-state
// function, default parameter values and 4-phase protocol phase encoding.
package muller_pipe_sync_pkg;

    localparam int unsigned DEF_N_IN   = 2;
    localparam int unsigned DEF_STAGES = 4;
    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_CNT_W  = 16;

    // Phase of one req/ack pair in a 4-phase handshake
    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,   // req=0 ack=0
        PH_REQ  = 2'd1,   // req=1 ack=0
        PH_ACK  = 2'd2,   // req=1 ack=1
        PH_RTZ  = 2'd3    // req=0 ack=1
    } phase_t;

    // Two-input C-element: set when both inputs high, clear when both low, else hold
    function automatic logic c_next(input logic a, input logic b_n, input logic q);
        return (a & b_n) | (q & (a | b_n));
    endfunction

    // Classify a req/ack pair into its handshake phase
    function automatic phase_t phase_of(input logic req, input logic ack);
        phase_t ph;
        case ({req, ack})
            2'b00:   ph = PH_IDLE;
            2'b10:   ph = PH_REQ;
            2'b11:   ph = PH_ACK;
            default: ph = PH_RTZ;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/muller_pipe_sync_c.sv
// Clocked N-input C-element with asynchronous active-high reset.
// Output goes high once all inputs are high, low once all are low, holds otherwise.
module muller_c_sync #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    output logic         q
);

    // C-element state: all-ones sets, all-zeros clears, mixed inputs hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (&a) begin
            q <= 1'b1;
        end else if (~|a) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/muller_pipe_sync.sv
// STAGES-deep synchronous 4-phase bundled-data micropipeline.
// N_IN requests are joined by one C-element ahead of stage 0; each stage is a
// C-element over (previous stage, inverted next stage) with a data latch that
// loads on the stage's rising edge.
// Optional: define MULLER_PIPE_STATS_EN to enable the completed-transfer
// counter on xfer_count; otherwise xfer_count is tied to zero.
module muller_pipe_sync
    import muller_pipe_sync_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned STAGES = DEF_STAGES,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [N_IN-1:0]   in_req,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ack,
    output logic              out_req,
    output logic [WIDTH-1:0]  out_data,
    input  logic              out_ack,
    output logic [STAGES-1:0] stage_c,
    output logic [CNT_W-1:0]  xfer_count
);

    logic              join_q;
    logic [STAGES-1:0] c;
    logic [STAGES-1:0] c_prev;     // c[i-1], with c[-1] = join_q
    logic [STAGES-1:0] ack_next;   // c[i+1], with c[STAGES] = out_ack
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  data     [STAGES];
    logic [WIDTH-1:0]  data_src [STAGES];

    assign c_prev   = {c[STAGES-2:0], join_q};
    assign ack_next = {out_ack, c[STAGES-1:1]};

    muller_c_sync #(.N(N_IN)) u_join (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .a   (in_req),
        .q   (join_q)
    );

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        muller_c_sync #(.N(2)) u_c (
            .clk (wb_clk_i),
            .rst (wb_rst_i),
            .a   ({c_prev[g], ~ack_next[g]}),
            .q   (c[g])
        );
    end

    // Detect which stages rise on this edge and select each stage's data source
    always_comb begin
        load        = '0;
        data_src[0] = in_data;
        for (int unsigned i = 0; i < STAGES; i++) begin
            load[i] = ~c[i] & c_next(c_prev[i], ~ack_next[i], c[i]);
        end
        for (int unsigned i = 1; i < STAGES; i++) begin
            data_src[i] = data[i-1];
        end
    end

    // Bundled-data latches: capture only when the stage's C-element rises
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (load[i]) begin
                    data[i] <= data_src[i];
                end
            end
        end
    end

`ifdef MULLER_PIPE_STATS_EN
    logic done;

    // A completed output handshake is the last stage falling
    assign done = c[STAGES-1] & ~c_next(c_prev[STAGES-1], ~out_ack, c[STAGES-1]);

    // Free-running transfer counter, wraps at 2^CNT_W
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            xfer_count <= '0;
        end else if (done) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end
`else
    assign xfer_count = '0;
`endif

    assign in_ack   = c[0];
    assign out_req  = c[STAGES-1];
    assign out_data = data[STAGES-1];
    assign stage_c  = c;

endmodule

// File: tb/tb_muller_pipe_sync.sv
// Self-checking bench for muller_pipe_sync. A second instance with CNT_W=4
// shares all inputs so counter wrap can be observed alongside the main DUT.
module tb_muller_pipe_sync;
    import muller_pipe_sync_pkg::*;

`ifdef MULLER_PIPE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_req = '0;
    logic [7:0]  in_data = '0;
    logic        out_ack = 1'b0;

    logic        in_ack, out_req;
    logic [7:0]  out_data;
    logic [3:0]  stage_c;
    logic [15:0] xfer_count;

    logic        in_ack_w, out_req_w;
    logic [7:0]  out_data_w;
    logic [3:0]  stage_c_w;
    logic [3:0]  xfer_count_w;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    bit          cons_en = 1'b0;
    int unsigned cons_max = 0;

    muller_pipe_sync #(.N_IN(2), .STAGES(4), .WIDTH(8), .CNT_W(16)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .stage_c    (stage_c),
        .xfer_count (xfer_count)
    );

    muller_pipe_sync #(.N_IN(2), .STAGES(4), .WIDTH(8), .CNT_W(4)) dut_w (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .in_req     (in_req),
        .in_data    (in_data),
        .in_ack     (in_ack_w),
        .out_req    (out_req_w),
        .out_data   (out_data_w),
        .out_ack    (out_ack),
        .stage_c    (stage_c_w),
        .xfer_count (xfer_count_w)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: pop and compare on every out_req rising
    initial begin : monitor
        logic       seen;
        logic [7:0] exp_d;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (out_req && !seen) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard: token out_data=%h appeared, required none (queue empty)", out_data);
                    end else begin
                        exp_d = sb.pop_front();
                        if (out_data !== exp_d) begin
                            errors++;
                            $display("FAIL scoreboard: out_data=%h required %h", out_data, exp_d);
                        end
                    end
                end
                seen = out_req;
            end
        end
    end

    // Consumer: 4-phase acknowledge with random delay when enabled
    initial begin : consumer
        forever begin
            @(negedge clk);
            if (!rst && cons_en && out_req && !out_ack) begin
                repeat ($urandom_range(cons_max, 0)) @(negedge clk);
                out_ack = 1'b1;
            end else if (out_ack && !out_req) begin
                out_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        while (in_ack !== 1'b0 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL send_idle: in_ack=%b required 0 within 500 cycles", in_ack);
        end
        in_data = d;
        in_req  = '1;
        sb.push_back(d);
        n = 0;
        while (in_ack !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL send_ack: in_ack=%b required 1 within 500 cycles", in_ack);
        end
        in_req = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || stage_c !== 4'b0000 || out_ack !== 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain: queue=%0d stage_c=%b required queue=0 stage_c=0000", sb.size(), stage_c);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        cons_en = 1'b0;
        in_req  = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ack, out_req, stage_c, out_data, xfer_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ack=%b out_req=%b stage_c=%b out_data=%h xfer=%0d required all 0",
                     in_ack, out_req, stage_c, out_data, xfer_count);
        end
        rst = 1'b0;
        @(negedge clk);
        cons_en = 1'b0;
        send(8'h5A);
        send(8'h3C);
        repeat (4) @(negedge clk);
        checks++;
        if (out_req !== 1'b1 || out_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_preload: out_req=%b out_data=%h required 1 5a", out_req, out_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ack, out_req, stage_c, out_data, xfer_count, xfer_count_w} !== '0) begin
            errors++;
            $display("FAIL reset_async: in_ack=%b out_req=%b stage_c=%b out_data=%h xfer=%0d required all 0",
                     in_ack, out_req, stage_c, out_data, xfer_count);
        end
        @(negedge clk);
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic exp_ack, exp_req;
        cons_en = 1'b0;
        in_data = 8'hA5;
        in_req  = 2'b11;
        sb.push_back(8'hA5);
        for (int e = 0; e <= 4; e++) begin
            @(negedge clk);
            exp_ack = (e >= 1);
            exp_req = (e >= 4);
            checks++;
            if (in_ack !== exp_ack) begin
                errors++;
                $display("FAIL latency_in_ack: after edge %0d in_ack=%b required %b", e, in_ack, exp_ack);
            end
            checks++;
            if (out_req !== exp_req) begin
                errors++;
                $display("FAIL latency_out_req: after edge %0d out_req=%b required %b", e, out_req, exp_req);
            end
        end
        checks++;
        if (out_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_data: out_data=%h required a5", out_data);
        end
        in_req  = '0;
        cons_en = 1'b1;
        drain();
    endtask

    task automatic test_join();
        bit bad;
        int n;
        cons_en = 1'b1;
        in_data = 8'h77;
        in_req  = 2'b01;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ack !== 1'b0 || stage_c !== 4'b0000) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL join_partial: in_ack=%b stage_c=%b required 0 0000", in_ack, stage_c);
        end
        in_req = 2'b11;
        sb.push_back(8'h77);
        n = 0;
        while (in_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL join_full: in_ack=%b required 1 within 50 cycles", in_ack);
        end
        in_req = 2'b10;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ack !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL join_hold: in_ack=%b required 1 while in_req=10", in_ack);
        end
        in_req = 2'b00;
        n = 0;
        while (in_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL join_release: in_ack=%b required 0 within 50 cycles", in_ack);
        end
        drain();
    endtask

    task automatic test_full();
        bit bad;
        int n;
        cons_en = 1'b0;
        send(8'h01);
        send(8'h02);
        repeat (8) @(negedge clk);
        // Tokens sit in stages 3 and 1 with bubbles at 2 and 0
        checks++;
        if (stage_c !== 4'b1010) begin
            errors++;
            $display("FAIL full_pattern: stage_c=%b required 1010", stage_c);
        end
        in_data = 8'h03;
        in_req  = 2'b11;
        sb.push_back(8'h03);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ack !== 1'b0 || out_data !== 8'h01 || stage_c !== 4'b1010) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL full_stall: in_ack=%b out_data=%h stage_c=%b required 0 01 1010",
                     in_ack, out_data, stage_c);
        end
        cons_en = 1'b1;
        n = 0;
        while (in_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL full_resume: in_ack=%b required 1 within 100 cycles", in_ack);
        end
        in_req = '0;
        drain();
    endtask

    task automatic test_streaming();
        logic [15:0] exp_cnt;
        logic [3:0]  exp_cnt_w;
        apply_reset();
        cons_en  = 1'b1;
        cons_max = 5;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom_range(255, 0)));
        end
        drain();
        exp_cnt   = STATS ? 16'd100 : 16'd0;
        exp_cnt_w = STATS ? 4'd4 : 4'd0;
        checks++;
        if (xfer_count !== exp_cnt) begin
            errors++;
            $display("FAIL stream_count: xfer_count=%0d required %0d", xfer_count, exp_cnt);
        end
        checks++;
        if (xfer_count_w !== exp_cnt_w) begin
            errors++;
            $display("FAIL stream_count_w4: xfer_count=%0d required %0d", xfer_count_w, exp_cnt_w);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_cnt;
        logic [3:0]  exp_cnt_w;
        apply_reset();
        cons_en  = 1'b1;
        cons_max = 2;
        for (int i = 0; i < 17; i++) begin
            send(8'(8'hC0 + i));
        end
        drain();
        exp_cnt   = STATS ? 16'd17 : 16'd0;
        exp_cnt_w = STATS ? 4'd1 : 4'd0;
        checks++;
        if (xfer_count_w !== exp_cnt_w) begin
            errors++;
            $display("FAIL wrap_count_w4: xfer_count=%0d required %0d", xfer_count_w, exp_cnt_w);
        end
        checks++;
        if (xfer_count !== exp_cnt) begin
            errors++;
            $display("FAIL wrap_count_w16: xfer_count=%0d required %0d", xfer_count, exp_cnt);
        end
    endtask

    initial begin : main
        test_reset();
        test_latency();
        test_join();
        test_full();
        test_streaming();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
